// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: word width, canonical NOP, fetch state
// encoding and the IF/ID register layout consumed by decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  // Byte address is a legal fetch target: word aligned and inside memory.
  function automatic logic addr_legal(input logic [XLEN-1:0] addr,
                                      input logic [XLEN:0]   limit);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and loads the IF/ID register, with stall, redirect and fault halt.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  localparam logic [XLEN:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  if_id_t          r_ifid;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;
  logic [XLEN-1:0] r_count;

  logic [XLEN-1:0] w_pc_plus4;
  logic            w_seq_end;
  logic            w_tgt_ok;

  // The 33-bit sum keeps a wrap past 2^32 from looking like a small legal address.
  assign w_pc_plus4 = r_pc + PC_STEP;
  assign w_seq_end  = (({1'b0, r_pc} + 33'd4) >= LIMIT);
  assign w_tgt_ok   = addr_legal(redirect_target, LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_ifid       <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (redirect_valid) begin
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
            if (w_tgt_ok) begin
              r_pc <= redirect_target;
            end else begin
              r_state      <= ST_HALT;
              r_fault      <= 1'b1;
              r_fault_addr <= redirect_target;
            end
          end else if (!stall) begin
            r_ifid  <= '{valid: 1'b1, instr: imem_rdata, pc: r_pc, pc_plus4: w_pc_plus4};
            r_count <= r_count + 32'd1;
            if (w_seq_end) begin
              r_state      <= ST_HALT;
              r_fault      <= 1'b1;
              r_fault_addr <= w_pc_plus4;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        ST_HALT: begin
          // A last instruction loaded on sequential-fault entry survives stalls.
          if (!stall) begin
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_valid    = r_ifid.valid;
  assign if_id_instr    = r_ifid.instr;
  assign if_id_pc       = r_ifid.pc;
  assign if_id_pc_plus4 = r_ifid.pc_plus4;
  assign fetch_fault    = r_fault;
  assign fault_addr     = r_fault_addr;
  assign fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural fetch model compared every cycle, plus
// hand-computed checkpoints for boot, stall, redirect, fault and async reset.
module tb_fetch_unit;

  localparam longint MEM_BYTES = 4096;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr),
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0:   w = 32'h00A0_0093;
      32'h4:   w = 32'h0010_0113;
      default: w = {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h0107};
    endcase
    return w;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = settling after reset, 1 = fetching, 2 = halted.
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_faddr, m_count;
  logic        m_valid, m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP;
      m_ipc = 0; m_ipc4 = 0; m_fault = 1'b0; m_faddr = 0; m_count = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (redirect_valid) begin
        m_valid = 1'b0;
        m_instr = NOP;
        if ((redirect_target % 4 == 0) && (longint'(redirect_target) < MEM_BYTES))
          m_pc = redirect_target;
        else begin
          m_phase = 2; m_fault = 1'b1; m_faddr = redirect_target;
        end
      end else if (!stall) begin
        m_valid = 1'b1;
        m_instr = mem_word(m_pc);
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_count = m_count + 32'd1;
        if (longint'(m_pc) + 4 >= MEM_BYTES) begin
          m_phase = 2; m_fault = 1'b1; m_faddr = m_pc + 32'd4;
        end else
          m_pc = m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end
  end

  always @(negedge clk) begin
    chk("model.imem_addr", imem_addr, m_pc);
    chk("model.if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("model.if_id_instr", if_id_instr, m_instr);
    chk("model.if_id_pc", if_id_pc, m_ipc);
    chk("model.if_id_pc_plus4", if_id_pc_plus4, m_ipc4);
    chk("model.fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    chk("model.fault_addr", fault_addr, m_faddr);
    chk("model.fetch_count", fetch_count, m_count);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, 32'h0);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'h0);
    chk({tag, ".instr"}, if_id_instr, NOP);
    chk({tag, ".count"}, fetch_count, 32'h0);
    chk({tag, ".fault"}, {31'b0, fetch_fault}, 32'h0);
    chk({tag, ".fault_addr"}, fault_addr, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] frozen_pc;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    step();
    chk_reset_state("reset");
    step();
    rst = 1'b0;

    // Boot cycle, then first two sequential loads.
    step();
    chk("boot.valid", {31'b0, if_id_valid}, 32'h0);
    chk("boot.imem_addr", imem_addr, 32'h0);
    step();
    chk("c2.instr", if_id_instr, 32'h00A0_0093);
    chk("c2.pc", if_id_pc, 32'h0);
    chk("c2.pc4", if_id_pc_plus4, 32'h4);
    step();
    chk("c3.imem_addr", imem_addr, 32'h8);
    chk("c3.pc", if_id_pc, 32'h4);
    chk("c3.instr", if_id_instr, 32'h0010_0113);
    chk("c3.count", fetch_count, 32'd2);
    step();
    step();
    chk("pre_stall.imem_addr", imem_addr, 32'h10);

    // Three stalled cycles hold everything.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("stall.imem_addr", imem_addr, 32'h10);
    chk("stall.pc", if_id_pc, 32'hC);
    chk("stall.count", fetch_count, 32'd4);
    stall = 1'b0;
    step();
    chk("unstall.pc", if_id_pc, 32'h10);
    chk("unstall.count", fetch_count, 32'd5);

    // Redirect beats a simultaneous stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    chk("redir.imem_addr", imem_addr, 32'h40);
    chk("redir.valid", {31'b0, if_id_valid}, 32'h0);
    chk("redir.instr", if_id_instr, NOP);
    chk("redir.count", fetch_count, 32'd5);
    step();
    chk("redir2.pc", if_id_pc, 32'h40);
    chk("redir2.valid", {31'b0, if_id_valid}, 32'h1);

    // Randomized legal operation against the model.
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_target = 32'($urandom_range(0, 511)) * 32'd4;
      step();
    end
    stall = 1'b0; redirect_valid = 1'b0;

    // Sequential run off the end of memory.
    redirect_valid = 1'b1; redirect_target = 32'hFF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("end.ff8.pc", if_id_pc, 32'hFF8);
    chk("end.ff8.fault", {31'b0, fetch_fault}, 32'h0);
    step();
    chk("end.ffc.pc", if_id_pc, 32'hFFC);
    chk("end.ffc.valid", {31'b0, if_id_valid}, 32'h1);
    chk("end.fault", {31'b0, fetch_fault}, 32'h1);
    chk("end.fault_addr", fault_addr, 32'h1000);
    chk("end.imem_addr", imem_addr, 32'hFFC);
    stall = 1'b1;
    step();
    chk("end.stall.valid", {31'b0, if_id_valid}, 32'h1);
    stall = 1'b0;
    step();
    chk("end.unstall.valid", {31'b0, if_id_valid}, 32'h0);
    chk("end.unstall.instr", if_id_instr, NOP);

    // Misaligned redirect target faults and freezes the unit.
    do_reset();
    step();
    step();
    step();
    frozen_pc = imem_addr;
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step();
    chk("bad.fault", {31'b0, fetch_fault}, 32'h1);
    chk("bad.fault_addr", fault_addr, 32'h42);
    chk("bad.valid", {31'b0, if_id_valid}, 32'h0);
    chk("bad.imem_addr", imem_addr, frozen_pc);
    for (int i = 0; i < 10; i++) begin
      stall = $urandom_range(0, 1) == 1;
      redirect_valid = $urandom_range(0, 1) == 1;
      redirect_target = 32'($urandom_range(0, 255)) * 32'd4;
      step();
    end
    chk("bad.hold.imem_addr", imem_addr, frozen_pc);
    chk("bad.hold.fault_addr", fault_addr, 32'h42);
    chk("bad.hold.valid", {31'b0, if_id_valid}, 32'h0);
    stall = 1'b0; redirect_valid = 1'b0;

    // Asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < 6; i++) step();
    chk("pre_async.count", fetch_count, 32'd5);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_state("async");
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_async.instr", if_id_instr, 32'h00A0_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
